// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared encodings for the unified memory responder
//
// Purpose: access-size encodings, FSM state enum and port-select encoding
// used by unified_mem_responder and mem_align_unit.
// Ports: none (package).
package mem_resp_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

endpackage

// File: rtl/unified_mem_responder_if.sv
// rtl/unified_mem_responder_if.sv - fetch and data request/response bundle
//
// Purpose: groups the fetch-port and data-port handshake signals.
// Modports:
//   master - core side: drives requests, receives ready and responses
//   slave  - responder side: receives requests, drives ready and responses
interface unified_mem_responder_if;

  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        if_rsp_err;

  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_addr;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] d_wdata;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;

  modport master (
    output if_req_valid, if_addr,
    output d_req_valid, d_addr, d_we, d_size, d_unsigned, d_wdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err
  );

  modport slave (
    input  if_req_valid, if_addr,
    input  d_req_valid, d_addr, d_we, d_size, d_unsigned, d_wdata,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err
  );

endinterface

// File: rtl/mem_align_unit.sv
// rtl/mem_align_unit.sv - byte/half/word lane alignment and store merge
//
// Purpose: combinational lane logic for one access against one stored word.
// Ports:
//   rd_word     in  32  word currently held in storage
//   addr_lo     in  2   byte offset within the word
//   size        in  2   SZ_BYTE / SZ_HALF / SZ_WORD, 2'b11 illegal
//   is_unsigned in  1   zero-extend loads when 1
//   wdata       in  32  store data, right-aligned
//   load_data   out 32  aligned, extended load result (0 on error)
//   store_word  out 32  rd_word with the addressed lanes replaced (rd_word on error)
//   err         out 1   misaligned or illegal size
module mem_align_unit
  import mem_resp_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic        err
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] wdata_sh;

  always_comb begin
    shamt     = {addr_lo, 3'b000};
    shifted   = rd_word >> shamt;
    wdata_sh  = wdata << shamt;
    err       = 1'b0;
    load_data = '0;
    lane_mask = '0;
    case (size)
      SZ_BYTE: begin
        lane_mask = 32'h0000_00FF << shamt;
        load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        err       = addr_lo[0];
        lane_mask = 32'h0000_FFFF << shamt;
        load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        err       = |addr_lo;
        lane_mask = 32'hFFFF_FFFF;
        load_data = rd_word;
      end
      default: err = 1'b1;
    endcase
    // An erroring access must neither return data nor touch any lane.
    if (err) begin
      load_data = '0;
      lane_mask = '0;
    end
    store_word = (rd_word & ~lane_mask) | (wdata_sh & lane_mask);
  end

endmodule

// File: rtl/unified_mem_responder.sv
// rtl/unified_mem_responder.sv - arbitrated fixed-latency unified I/D memory responder
//
// Purpose: serves a fetch port and a data load/store port from one
// single-ported word array with round-robin arbitration and fixed latency.
// Optional feature macro: MEM_RESP_STATS_EN (adds response/error counters).
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous active-low reset
//   bus          slave     fetch/data request and response handshakes
//   busy         out  1   high whenever the FSM is not idle
//   stat_if_cnt  out  16  fetch responses delivered (MEM_RESP_STATS_EN only)
//   stat_d_cnt   out  16  data responses delivered (MEM_RESP_STATS_EN only)
//   stat_err_cnt out  8   erroring responses, saturating (MEM_RESP_STATS_EN only)
module unified_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_W = 10,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  unified_mem_responder_if.slave bus,
  output logic                   busy
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [15:0]            stat_if_cnt,
  output logic [15:0]            stat_d_cnt,
  output logic [7:0]             stat_err_cnt
`endif
);

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  state_e state, state_n;
  logic [3:0] cnt, cnt_n;
  port_e      prefer;
  logic       grant_if, grant_d, do_access;

  port_e              cap_port;
  logic [DEPTH_W-1:0] cap_idx;
  logic [1:0]         cap_lo;
  logic               cap_we;
  logic [1:0]         cap_size;
  logic               cap_uns;
  logic [31:0]        cap_wdata;

  logic        if_rsp_valid_q, if_rsp_err_q, d_rsp_valid_q, d_rsp_err_q;
  logic [31:0] if_rsp_data_q, d_rsp_data_q;

  logic [31:0] mem [0:(1<<DEPTH_W)-1];
  logic [31:0] rd_word, load_data, store_word;
  logic        acc_err;

  // Address bits above the storage index are ignored so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.if_addr[31:DEPTH_W+2], bus.d_addr[31:DEPTH_W+2]};

  // Ready is only offered in IDLE; on contention only the preferred port sees it.
  assign bus.if_req_ready = (state == ST_IDLE) && (!bus.d_req_valid || prefer == PORT_IF);
  assign bus.d_req_ready  = (state == ST_IDLE) && (!bus.if_req_valid || prefer == PORT_D);
  assign grant_if = bus.if_req_valid && bus.if_req_ready;
  assign grant_d  = bus.d_req_valid && bus.d_req_ready;

  assign busy = (state != ST_IDLE);

  assign bus.if_rsp_valid = if_rsp_valid_q;
  assign bus.if_rsp_data  = if_rsp_data_q;
  assign bus.if_rsp_err   = if_rsp_err_q;
  assign bus.d_rsp_valid  = d_rsp_valid_q;
  assign bus.d_rsp_data   = d_rsp_data_q;
  assign bus.d_rsp_err    = d_rsp_err_q;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    do_access = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_if || grant_d) begin
          state_n = ST_WAIT;
          cnt_n   = LAT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          do_access = 1'b1;
          state_n   = ST_RESP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Fetches go through the same lane logic as an unsigned word load.
  assign rd_word = mem[cap_idx];

  mem_align_unit u_align (
    .rd_word     (rd_word),
    .addr_lo     (cap_lo),
    .size        (cap_size),
    .is_unsigned (cap_uns),
    .wdata       (cap_wdata),
    .load_data   (load_data),
    .store_word  (store_word),
    .err         (acc_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      prefer         <= PORT_IF;
      cap_port       <= PORT_IF;
      cap_idx        <= '0;
      cap_lo         <= '0;
      cap_we         <= 1'b0;
      cap_size       <= SZ_WORD;
      cap_uns        <= 1'b0;
      cap_wdata      <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_err_q   <= 1'b0;
      if_rsp_data_q  <= '0;
      d_rsp_valid_q  <= 1'b0;
      d_rsp_err_q    <= 1'b0;
      d_rsp_data_q   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;

      if (grant_if) begin
        cap_port  <= PORT_IF;
        cap_idx   <= bus.if_addr[DEPTH_W+1:2];
        cap_lo    <= bus.if_addr[1:0];
        cap_we    <= 1'b0;
        cap_size  <= SZ_WORD;
        cap_uns   <= 1'b1;
        cap_wdata <= '0;
        prefer    <= PORT_D;
      end else if (grant_d) begin
        cap_port  <= PORT_D;
        cap_idx   <= bus.d_addr[DEPTH_W+1:2];
        cap_lo    <= bus.d_addr[1:0];
        cap_we    <= bus.d_we;
        cap_size  <= bus.d_size;
        cap_uns   <= bus.d_unsigned;
        cap_wdata <= bus.d_wdata;
        prefer    <= PORT_IF;
      end

      // Response registers only carry content during the one-cycle strobe.
      if_rsp_valid_q <= 1'b0;
      if_rsp_err_q   <= 1'b0;
      if_rsp_data_q  <= '0;
      d_rsp_valid_q  <= 1'b0;
      d_rsp_err_q    <= 1'b0;
      d_rsp_data_q   <= '0;
      if (do_access) begin
        if (cap_port == PORT_IF) begin
          if_rsp_valid_q <= 1'b1;
          if_rsp_err_q   <= acc_err;
          if_rsp_data_q  <= load_data;
        end else begin
          d_rsp_valid_q <= 1'b1;
          d_rsp_err_q   <= acc_err;
          d_rsp_data_q  <= cap_we ? 32'h0 : load_data;
        end
      end
    end
  end

  // Storage is not reset; a reset before the access edge leaves do_access low.
  always_ff @(posedge clk) begin
    if (do_access && cap_we && !acc_err) begin
      mem[cap_idx] <= store_word;
    end
  end

`ifdef MEM_RESP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_if_cnt  <= '0;
      stat_d_cnt   <= '0;
      stat_err_cnt <= '0;
    end else if (do_access) begin
      if (cap_port == PORT_IF) begin
        stat_if_cnt <= stat_if_cnt + 16'd1;
      end else begin
        stat_d_cnt <= stat_d_cnt + 16'd1;
      end
      if (acc_err && stat_err_cnt != 8'hFF) begin
        stat_err_cnt <= stat_err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_unified_mem_responder.sv
// tb/tb_unified_mem_responder.sv - scoreboard bench for unified_mem_responder
//
// Purpose: drives fetch and data requests, queues expected responses and
// compares them as the responder strobes them out.
// Optional feature macro: MEM_RESP_STATS_EN (enables the counter scenario).
module tb_unified_mem_responder;

  localparam int         LAT   = 2;
  localparam logic       P_IF  = 1'b0;
  localparam logic       P_D   = 1'b1;
  localparam logic [1:0] S_B   = 2'b00;
  localparam logic [1:0] S_H   = 2'b01;
  localparam logic [1:0] S_W   = 2'b10;
  localparam logic [1:0] S_ILL = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  unified_mem_responder_if bus();

`ifdef MEM_RESP_STATS_EN
  logic [15:0] stat_if_cnt, stat_d_cnt;
  logic [7:0]  stat_err_cnt;
`endif

  unified_mem_responder #(.DEPTH_W(10), .LATENCY(LAT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
`ifdef MEM_RESP_STATS_EN
    ,
    .stat_if_cnt  (stat_if_cnt),
    .stat_d_cnt   (stat_d_cnt),
    .stat_err_cnt (stat_err_cnt)
`endif
  );

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  logic prev_valid = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic        any_v;
    logic        got_port;
    logic [31:0] got_data;
    logic        got_err;
    any_v    = bus.if_rsp_valid | bus.d_rsp_valid;
    got_port = bus.d_rsp_valid;
    got_data = got_port ? bus.d_rsp_data : bus.if_rsp_data;
    got_err  = got_port ? bus.d_rsp_err : bus.if_rsp_err;
    if (any_v) begin
      n_tests++;
      if (prev_valid) begin
        n_fail++;
        $display("FAIL rsp_strobe: valid high on consecutive cycles, required single-cycle strobe");
      end else if (bus.if_rsp_valid && bus.d_rsp_valid) begin
        n_fail++;
        $display("FAIL rsp_both: both ports strobed, required one");
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: port=%0d data=%h err=%0d, required no response", got_port, got_data, got_err);
      end else begin
        e = exp_q.pop_front();
        if (got_port !== e.port || got_data !== e.data || got_err !== e.err) begin
          n_fail++;
          $display("FAIL rsp_compare: got port=%0d data=%h err=%0d, required port=%0d data=%h err=%0d",
                   got_port, got_data, got_err, e.port, e.data, e.err);
        end
      end
    end
    prev_valid = any_v;
  end

  task automatic wait_done();
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL rsp_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send_d(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err);
    bit acc = 0;
    @(negedge clk);
    bus.d_req_valid = 1'b1;
    bus.d_we        = we;
    bus.d_addr      = addr;
    bus.d_size      = size;
    bus.d_unsigned  = uns;
    bus.d_wdata     = wdata;
    for (int k = 0; k < 64 && !acc; k++) begin
      #1;
      if (bus.d_req_ready === 1'b1) begin
        acc = 1;
        exp_q.push_back('{port: P_D, data: exp_data, err: exp_err});
        @(posedge clk);
        #1;
        // Scramble the payload after acceptance; the captured copy must be used.
        bus.d_req_valid = 1'b0;
        bus.d_addr      = $urandom;
        bus.d_wdata     = $urandom;
        bus.d_size      = 2'($urandom_range(0, 3));
        bus.d_we        = 1'($urandom_range(0, 1));
        bus.d_unsigned  = 1'($urandom_range(0, 1));
      end else begin
        @(negedge clk);
      end
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL d_accept_timeout: d_req_ready=%b, required 1", bus.d_req_ready);
      bus.d_req_valid = 1'b0;
    end
    wait_done();
  endtask

  task automatic send_if(input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err);
    bit acc = 0;
    @(negedge clk);
    bus.if_req_valid = 1'b1;
    bus.if_addr      = addr;
    for (int k = 0; k < 64 && !acc; k++) begin
      #1;
      if (bus.if_req_ready === 1'b1) begin
        acc = 1;
        exp_q.push_back('{port: P_IF, data: exp_data, err: exp_err});
        @(posedge clk);
        #1;
        bus.if_req_valid = 1'b0;
        bus.if_addr      = $urandom;
      end else begin
        @(negedge clk);
      end
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL if_accept_timeout: if_req_ready=%b, required 1", bus.if_req_ready);
      bus.if_req_valid = 1'b0;
    end
    wait_done();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || bus.if_rsp_valid !== 1'b0 || bus.d_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b if_v=%b d_v=%b, required 0 0 0", busy, bus.if_rsp_valid, bus.d_rsp_valid);
    end
    n_tests++;
    if (bus.if_rsp_err !== 1'b0 || bus.d_rsp_err !== 1'b0 || bus.if_rsp_data !== 32'h0 || bus.d_rsp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rsp: if_err=%b d_err=%b if_data=%h d_data=%h, required all 0",
               bus.if_rsp_err, bus.d_rsp_err, bus.if_rsp_data, bus.d_rsp_data);
    end
    n_tests++;
    if (bus.if_req_ready !== 1'b1 || bus.d_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: if_rdy=%b d_rdy=%b, required 1 1", bus.if_req_ready, bus.d_req_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fetch();
    int lat = 0;
    send_d(1'b1, 32'h0, S_W, 1'b0, 32'h0000_0013, 32'h0, 1'b0);
    @(negedge clk);
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'h0;
    #1;
    n_tests++;
    if (bus.if_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_ready: if_req_ready=%b, required 1", bus.if_req_ready);
    end
    exp_q.push_back('{port: P_IF, data: 32'h0000_0013, err: 1'b0});
    @(posedge clk);
    #1;
    bus.if_req_valid = 1'b0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(posedge clk);
      #1;
      if (bus.if_rsp_valid === 1'b1) lat = c;
    end
    n_tests++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL fetch_latency: response %0d edges after accept, required %0d", lat, LAT);
    end
    wait_done();
    send_if(32'h0000_0002, 32'h0, 1'b1);
    send_if(32'h0000_1000, 32'h0000_0013, 1'b0);
  endtask

  task automatic test_byte_half();
    send_d(1'b1, 32'h100, S_W, 1'b0, 32'h1122_3344, 32'h0, 1'b0);
    send_d(1'b1, 32'h101, S_B, 1'b0, 32'hABCD_EF80, 32'h0, 1'b0);
    send_d(1'b0, 32'h101, S_B, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0);
    send_d(1'b0, 32'h101, S_B, 1'b1, 32'h0, 32'h0000_0080, 1'b0);
    send_d(1'b0, 32'h100, S_W, 1'b0, 32'h0, 32'h1122_8044, 1'b0);
    send_d(1'b0, 32'h102, S_H, 1'b0, 32'h0, 32'h0000_1122, 1'b0);
    send_d(1'b1, 32'h102, S_H, 1'b0, 32'h1234_BEEF, 32'h0, 1'b0);
    send_d(1'b0, 32'h102, S_H, 1'b0, 32'h0, 32'hFFFF_BEEF, 1'b0);
    send_d(1'b0, 32'h103, S_B, 1'b1, 32'h0, 32'h0000_00BE, 1'b0);
  endtask

  task automatic test_misaligned();
    send_d(1'b1, 32'h102, S_W,   1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1);
    send_d(1'b0, 32'h100, S_W,   1'b0, 32'h0, 32'hBEEF_8044, 1'b0);
    send_d(1'b0, 32'h100, S_ILL, 1'b0, 32'h0, 32'h0, 1'b1);
    send_d(1'b0, 32'h101, S_H,   1'b0, 32'h0, 32'h0, 1'b1);
    send_d(1'b1, 32'h103, S_H,   1'b0, 32'h0000_5555, 32'h0, 1'b1);
    send_d(1'b0, 32'h100, S_W,   1'b0, 32'h0, 32'hBEEF_8044, 1'b0);
  endtask

  task automatic test_arbitration();
    logic order [4];
    logic want  [4] = '{P_IF, P_D, P_IF, P_D};
    int   n = 0;
    pulse_reset();
    @(negedge clk);
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'h0;
    bus.d_req_valid  = 1'b1;
    bus.d_we         = 1'b0;
    bus.d_addr       = 32'h100;
    bus.d_size       = S_W;
    bus.d_unsigned   = 1'b0;
    for (int k = 0; k < 80 && n < 4; k++) begin
      #1;
      if (bus.if_req_ready === 1'b1) begin
        n_tests++;
        if (bus.d_req_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL arb_loser_ready: d_req_ready=%b while fetch wins, required 0", bus.d_req_ready);
        end
        order[n] = P_IF;
        n++;
        exp_q.push_back('{port: P_IF, data: 32'h0000_0013, err: 1'b0});
      end else if (bus.d_req_ready === 1'b1) begin
        n_tests++;
        if (bus.if_req_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL arb_loser_ready: if_req_ready=%b while data wins, required 0", bus.if_req_ready);
        end
        order[n] = P_D;
        n++;
        exp_q.push_back('{port: P_D, data: 32'hBEEF_8044, err: 1'b0});
      end
      if (n < 4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.if_req_valid = 1'b0;
    bus.d_req_valid  = 1'b0;
    n_tests++;
    if (n != 4) begin
      n_fail++;
      $display("FAIL arb_grants: %0d grants seen, required 4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (order[i] !== want[i]) begin
          n_fail++;
          $display("FAIL arb_order[%0d]: port=%0d, required %0d", i, order[i], want[i]);
        end
      end
    end
    wait_done();
  endtask

  task automatic test_wrap_reset();
    send_d(1'b1, 32'h0000_1000, S_W, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0);
    send_d(1'b0, 32'h0000_0000, S_W, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0);
    send_if(32'h0, 32'hCAFE_F00D, 1'b0);
    send_d(1'b1, 32'h200, S_W, 1'b0, 32'h1234_5678, 32'h0, 1'b0);
    // Store accepted, then reset lands while it is still waiting.
    @(negedge clk);
    bus.d_req_valid = 1'b1;
    bus.d_we        = 1'b1;
    bus.d_addr      = 32'h200;
    bus.d_size      = S_W;
    bus.d_wdata     = 32'hFFFF_FFFF;
    #1;
    n_tests++;
    if (bus.d_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_ready: d_req_ready=%b, required 1", bus.d_req_ready);
    end
    @(posedge clk);
    #1;
    bus.d_req_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_wait: busy=%b after accept, required 1", busy);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_busy: busy=%b, required 0", busy);
    end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send_d(1'b0, 32'h200, S_W, 1'b0, 32'h0, 32'h1234_5678, 1'b0);
  endtask

`ifdef MEM_RESP_STATS_EN
  task automatic test_stats();
    pulse_reset();
    #1;
    n_tests++;
    if (stat_if_cnt !== 16'd0 || stat_d_cnt !== 16'd0 || stat_err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL stats_reset: if=%0d d=%0d err=%0d, required 0 0 0", stat_if_cnt, stat_d_cnt, stat_err_cnt);
    end
    repeat (3) send_if(32'h0, 32'hCAFE_F00D, 1'b0);
    send_d(1'b0, 32'h100, S_W, 1'b0, 32'h0, 32'hBEEF_8044, 1'b0);
    send_d(1'b0, 32'h102, S_W, 1'b0, 32'h0, 32'h0, 1'b1);
    n_tests++;
    if (stat_if_cnt !== 16'd3 || stat_d_cnt !== 16'd2 || stat_err_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL stats_count: if=%0d d=%0d err=%0d, required 3 2 1", stat_if_cnt, stat_d_cnt, stat_err_cnt);
    end
  endtask
`endif

  initial begin
    bus.if_req_valid = 1'b0;
    bus.if_addr      = '0;
    bus.d_req_valid  = 1'b0;
    bus.d_addr       = '0;
    bus.d_we         = 1'b0;
    bus.d_size       = S_W;
    bus.d_unsigned   = 1'b0;
    bus.d_wdata      = '0;
    #2 rst = 1'b0;
    test_reset();
    test_fetch();
    test_byte_half();
    test_misaligned();
    test_arbitration();
    test_wrap_reset();
`ifdef MEM_RESP_STATS_EN
    test_stats();
`endif
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
